// File: rtl/validator_pkg.sv
// Shared definitions for the validator_array block.
//   - Default widths and sizes for the array and its lane buffers.
//   - CNT_W: width of the pass/drop statistics counters.
//   - sat_inc(): counter increment that sticks at all-ones instead of wrapping.
package validator_pkg;

    localparam int W_DEF     = 128;
    localparam int LANES_DEF = 4;
    localparam int DEPTH_DEF = 8;
    localparam int DW_DEF    = 8;
    localparam int CNT_W     = 32;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end
        return v + 1'b1;
    endfunction

endpackage

// File: rtl/validator_array_fifo.sv
// sync_fifo: single-clock show-ahead FIFO used as a per-lane input buffer.
//   clk, rst        clock and synchronous active-high reset (pointers only)
//   wr_en, wr_data  push; ignored while full
//   rd_en           pop the head; ignored while empty
//   rd_data         current head entry (valid whenever !empty)
//   empty, full     occupancy flags
// Pointers carry one extra wrap bit so that equal indices can be resolved
// into either empty (same wrap) or full (opposite wrap).
module sync_fifo
    import validator_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         empty,
    output logic         full
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          do_wr;
    logic          do_rd;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_wr    = wr_en && !full;
        do_rd    = rd_en && !empty;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_wr};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_rd};
        rd_data  = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset: an entry is only observable after it is written.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/validator_array.sv
// validator_array: screens transactions against a leading-zero difficulty,
// deals the passing ones round-robin to LANES external validator lanes
// (each behind a sync_fifo) and merges lane results back in dispatch order.
//   clk, rst                   clock, synchronous active-high reset
//   i_valid/i_ready            transaction handshake; i_transaction, i_difficulty
//   lane_valid_o/lane_data_o   per-lane buffer head (show-ahead), lane_ack_i pops
//   res_valid_i/res_data_i     per-lane results, res_ack_o takes one
//   o_valid/o_hash/o_ready     merged, order-preserving result stream
//   o_pass_count/o_drop_count  saturating statistics
module validator_array
    import validator_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int LANES = LANES_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_valid,
    input  logic [W-1:0]       i_transaction,
    output logic               i_ready,
    input  logic [DW-1:0]      i_difficulty,
    output logic [LANES-1:0]   lane_valid_o,
    output logic [LANES*W-1:0] lane_data_o,
    input  logic [LANES-1:0]   lane_ack_i,
    input  logic [LANES-1:0]   res_valid_i,
    input  logic [LANES*W-1:0] res_data_i,
    output logic [LANES-1:0]   res_ack_o,
    output logic               o_valid,
    output logic [W-1:0]       o_hash,
    input  logic               o_ready,
    output logic [CNT_W-1:0]   o_pass_count,
    output logic [CNT_W-1:0]   o_drop_count
);

    localparam int PW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [PW-1:0] LAST = PW'(LANES - 1);

    logic [LANES-1:0] fifo_empty;
    logic [LANES-1:0] fifo_full;
    logic [LANES-1:0] fifo_wr;
    logic [LANES-1:0] fifo_rd;

    logic [PW-1:0]    dptr_q, dptr_d;
    logic [PW-1:0]    cptr_q, cptr_d;
    logic             rdy_en_q;
    logic             o_valid_q, o_valid_d;
    logic [W-1:0]     o_hash_q, o_hash_d;
    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic             pass;
    logic             take;
    logic             res_take;

    // Leading-zero screen: bit W-1-i is examined when i < d, so d >= W
    // demands the whole word be zero and d = 0 examines nothing.
    always_comb begin
        pass = 1'b1;
        for (int i = 0; i < W; i++) begin
            if (($unsigned(i) < 32'(i_difficulty)) && i_transaction[W-1-i]) begin
                pass = 1'b0;
            end
        end
    end

    // Dispatch: the source is gated by the current target lane even for
    // transactions that will be dropped, so rotation order is never skipped.
    // rdy_en_q holds i_ready low for the first cycle out of reset.
    always_comb begin
        i_ready = rdy_en_q && !fifo_full[dptr_q];
        take    = i_valid && i_ready;
        fifo_wr = '0;
        fifo_wr[dptr_q] = take && pass;
        dptr_d  = dptr_q;
        if (take && pass) begin
            dptr_d = (dptr_q == LAST) ? '0 : dptr_q + 1'b1;
        end
        pass_cnt_d = (take && pass)  ? sat_inc(pass_cnt_q) : pass_cnt_q;
        drop_cnt_d = (take && !pass) ? sat_inc(drop_cnt_q) : drop_cnt_q;
    end

    always_comb begin
        lane_valid_o = ~fifo_empty;
        fifo_rd      = lane_ack_i & ~fifo_empty;
    end

    // Collect: only the lane named by cptr may hand over a result, which is
    // what restores dispatch order across lanes.
    always_comb begin
        res_take  = res_valid_i[cptr_q] && (!o_valid_q || o_ready) && !rst;
        res_ack_o = '0;
        res_ack_o[cptr_q] = res_take;
        cptr_d    = cptr_q;
        o_valid_d = o_valid_q;
        o_hash_d  = o_hash_q;
        if (res_take) begin
            cptr_d    = (cptr_q == LAST) ? '0 : cptr_q + 1'b1;
            o_valid_d = 1'b1;
            o_hash_d  = res_data_i[cptr_q*W +: W];
        end else if (o_ready) begin
            o_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dptr_q     <= '0;
            cptr_q     <= '0;
            rdy_en_q   <= 1'b0;
            o_valid_q  <= 1'b0;
            o_hash_q   <= '0;
            pass_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            dptr_q     <= dptr_d;
            cptr_q     <= cptr_d;
            rdy_en_q   <= 1'b1;
            o_valid_q  <= o_valid_d;
            o_hash_q   <= o_hash_d;
            pass_cnt_q <= pass_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_comb begin
        o_valid      = o_valid_q;
        o_hash       = o_hash_q;
        o_pass_count = pass_cnt_q;
        o_drop_count = drop_cnt_q;
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        sync_fifo #(
            .W     (W),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (fifo_wr[k]),
            .wr_data (i_transaction),
            .rd_en   (fifo_rd[k]),
            .rd_data (lane_data_o[k*W +: W]),
            .empty   (fifo_empty[k]),
            .full    (fifo_full[k])
        );
    end

endmodule

// File: tb/tb_validator_array.sv
module tb_validator_array;

    localparam int W     = 128;
    localparam int LANES = 4;
    localparam int DEPTH = 2;
    localparam int DW    = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               i_valid;
    logic [W-1:0]       i_transaction;
    logic               i_ready;
    logic [DW-1:0]      i_difficulty;
    logic [LANES-1:0]   lane_valid_o;
    logic [LANES*W-1:0] lane_data_o;
    logic [LANES-1:0]   lane_ack_i;
    logic [LANES-1:0]   res_valid_i;
    logic [LANES*W-1:0] res_data_i;
    logic [LANES-1:0]   res_ack_o;
    logic               o_valid;
    logic [W-1:0]       o_hash;
    logic               o_ready;
    logic [31:0]        o_pass_count;
    logic [31:0]        o_drop_count;

    validator_array #(.W(W), .LANES(LANES), .DEPTH(DEPTH), .DW(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_valid       (i_valid),
        .i_transaction (i_transaction),
        .i_ready       (i_ready),
        .i_difficulty  (i_difficulty),
        .lane_valid_o  (lane_valid_o),
        .lane_data_o   (lane_data_o),
        .lane_ack_i    (lane_ack_i),
        .res_valid_i   (res_valid_i),
        .res_data_i    (res_data_i),
        .res_ack_o     (res_ack_o),
        .o_valid       (o_valid),
        .o_hash        (o_hash),
        .o_ready       (o_ready),
        .o_pass_count  (o_pass_count),
        .o_drop_count  (o_drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        int           t;
    } res_t;

    int               tests = 0;
    int               fails = 0;
    int               cyc = 0;
    logic [W-1:0]     exp_q [$];
    res_t             rq [LANES][$];
    int               pops [LANES];
    int               dly [LANES];
    logic             auto_ack = 1'b0;
    logic [LANES-1:0] one_shot = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Lane bank model: pops heads, returns each popped word as its result
    // after a per-lane delay (lane 0 slowest), in pop order per lane.
    initial begin : lane_model
        logic [LANES-1:0] took;
        logic [W-1:0]     cap [LANES];
        lane_ack_i  = '0;
        res_valid_i = '0;
        res_data_i  = '0;
        for (int k = 0; k < LANES; k++) begin
            pops[k] = 0;
            dly[k]  = 2 * (LANES - k);
            cap[k]  = '0;
        end
        forever begin
            @(negedge clk);
            took = res_ack_o;
            @(posedge clk);
            #1;
            for (int k = 0; k < LANES; k++) begin
                if (lane_ack_i[k]) begin
                    rq[k].push_back('{d: cap[k], t: cyc + dly[k]});
                    pops[k]++;
                end
                if (took[k] && rq[k].size() > 0) void'(rq[k].pop_front());
                if (rst) rq[k].delete();
                lane_ack_i[k] = (auto_ack || one_shot[k]) && (lane_valid_o[k] === 1'b1) && !rst;
                if (lane_ack_i[k]) one_shot[k] = 1'b0;
                cap[k] = lane_data_o[k*W +: W];
                res_valid_i[k] = (rq[k].size() > 0) && (rq[k][0].t <= cyc);
                res_data_i[k*W +: W] = (rq[k].size() > 0) ? rq[k][0].d : '0;
            end
        end
    end

    // Output scoreboard: every transfer must match the oldest expected word.
    initial begin : monitor
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (!rst && o_valid === 1'b1 && o_ready === 1'b1) begin
                tests++;
                if (exp_q.size() == 0) begin
                    assert (0) else begin
                        fails++;
                        $error("FAIL out_extra: got %0h want none", o_hash);
                    end
                end else begin
                    e = exp_q.pop_front();
                    assert (o_hash === e) else begin
                        fails++;
                        $error("FAIL out_order: got %0h want %0h", o_hash, e);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit ref_pass(input logic [W-1:0] x, input int d);
        if (d == 0) return 1'b1;
        if (d >= W) return (x == '0);
        return ((x >> (W - d)) == '0);
    endfunction

    // Offer one transaction (called just after a rising edge); returns just
    // after the edge that consumed it.
    task automatic send(input logic [W-1:0] x, input int d);
        bit ok = 1'b0;
        i_valid       = 1'b1;
        i_transaction = x;
        i_difficulty  = DW'(d);
        for (int n = 0; n < 60 && !ok; n++) begin
            @(negedge clk);
            if (i_ready === 1'b1) ok = 1'b1;
            else tick();
        end
        if (ok) begin
            if (ref_pass(x, d)) exp_q.push_back(x);
            tick();
        end else begin
            check("send_timeout", 0, 1);
        end
        i_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && o_valid === 1'b0) done = 1'b1;
        end
        check("drain", W'(done), 1);
    endtask

    initial begin : stim
        rst           = 1'b1;
        i_valid       = 1'b0;
        i_transaction = '0;
        i_difficulty  = '0;
        o_ready       = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_i_ready", W'(i_ready), 0);
        check("rst_lane_valid", W'(lane_valid_o), 0);
        check("rst_res_ack", W'(res_ack_o), 0);
        check("rst_o_valid", W'(o_valid), 0);
        check("rst_o_hash", o_hash, 0);
        check("rst_pass_cnt", W'(o_pass_count), 0);
        check("rst_drop_cnt", W'(o_drop_count), 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("ready_first_cycle", W'(i_ready), 0);
        @(negedge clk);
        check("ready_after_rst", W'(i_ready), 1);
        tick();

        // Order across lanes with reverse lane latency
        auto_ack = 1'b1;
        for (int i = 1; i <= 8; i++) send(W'(i), 0);
        wait_drain();
        check("order_pass_cnt", W'(o_pass_count), 8);
        for (int k = 0; k < LANES; k++) check("order_lane_pops", W'(pops[k]), 2);

        // Filter
        auto_ack = 1'b0;
        tick();
        send({8'h0F, 120'h0}, 4);
        send({8'hF0, 120'h0}, 4);
        send('0, 4);
        send('0, 200);
        @(negedge clk);
        check("filter_drop_cnt", W'(o_drop_count), 1);
        check("filter_pass_cnt", W'(o_pass_count), 11);
        check("filter_dptr3", W'(lane_valid_o), 4'b0111);
        auto_ack = 1'b1;
        wait_drain();
        tick();
        send(W'(32'hCAFE), 0);
        wait_drain();

        // Backpressure with DEPTH=2 and no lane acks
        auto_ack = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) send(W'(32'h100 + i), 0);
        i_valid       = 1'b1;
        i_transaction = W'(32'h108);
        i_difficulty  = '0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check("bp_ready_low", W'(i_ready), 0);
        end
        check("bp_all_full", W'(lane_valid_o), 4'hF);
        one_shot[0] = 1'b1;
        @(negedge clk);
        check("bp_ready_still_low", W'(i_ready), 0);
        check("bp_lane0_head", lane_data_o[W-1:0], W'(32'h100));
        @(negedge clk);
        check("bp_ready_rise", W'(i_ready), 1);
        exp_q.push_back(W'(32'h108));
        tick();
        i_valid = 1'b0;
        @(negedge clk);
        check("bp_lane0_next", lane_data_o[W-1:0], W'(32'h104));
        check("bp_pass_cnt", W'(o_pass_count), 21);
        auto_ack = 1'b1;
        wait_drain();

        // Output stall
        tick();
        o_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(W'(32'h200 + i), 0);
        repeat (16) @(negedge clk);
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            check("stall_o_valid", W'(o_valid), 1);
            check("stall_o_hash", o_hash, W'(32'h200));
            check("stall_res_ack", W'(res_ack_o), 0);
        end
        tick();
        o_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            check("stall_burst_valid", W'(o_valid), 1);
        end
        wait_drain();

        // Reset mid-run
        tick();
        o_ready = 1'b0;
        send(W'(32'h300), 0);
        begin
            bit seen = 1'b0;
            for (int n = 0; n < 40 && !seen; n++) begin
                @(negedge clk);
                if (o_valid === 1'b1) seen = 1'b1;
            end
            check("mid_o_valid_set", W'(seen), 1);
        end
        auto_ack = 1'b0;
        tick();
        send(W'(32'h301), 0);
        send(W'(32'h302), 0);
        send(W'(32'h303), 0);
        @(negedge clk);
        check("mid_buffered", W'(lane_valid_o), 4'b1101);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("mid_i_ready", W'(i_ready), 0);
        check("mid_lane_valid", W'(lane_valid_o), 0);
        check("mid_res_ack", W'(res_ack_o), 0);
        check("mid_o_valid", W'(o_valid), 0);
        check("mid_o_hash", o_hash, 0);
        check("mid_pass_cnt", W'(o_pass_count), 0);
        rst = 1'b0;
        @(negedge clk);
        tick();
        send(W'(32'h400), 0);
        @(negedge clk);
        check("post_rst_lane0", W'(lane_valid_o), 4'b0001);
        check("post_rst_data", lane_data_o[W-1:0], W'(32'h400));
        check("post_rst_pass_cnt", W'(o_pass_count), 1);
        o_ready  = 1'b1;
        auto_ack = 1'b1;
        wait_drain();

        // Drop counter saturation
        force dut.drop_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.drop_cnt_q;
        @(negedge clk);
        check("sat_preload", W'(o_drop_count), W'(32'hFFFF_FFFE));
        tick();
        send({8'hFF, 120'h0}, 8);
        @(negedge clk);
        check("sat_first", W'(o_drop_count), W'(32'hFFFF_FFFF));
        tick();
        send({8'hFF, 120'h0}, 8);
        send({8'h80, 120'h0}, 8);
        @(negedge clk);
        check("sat_hold", W'(o_drop_count), W'(32'hFFFF_FFFF));
        check("sat_pass_cnt", W'(o_pass_count), 1);
        check("end_exp_empty", W'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/validator_array.md
# validator_array

Single-clock, parametrised successor to the filter/validate/hash pipeline. It screens incoming transactions against a runtime difficulty level and deals accepted ones round-robin across `LANES` external validator lanes, each fed through its own buffer. It then collects lane results in strict dispatch order, so the merged output stream preserves input order. It sits between the transaction source and a bank of `trans_validator`/`hash_gen` lane instances.

## Interface
Parameters:
- `W`, 128: transaction and result width in bits.
- `LANES`, 4: number of validator lanes; ≥1.
- `DEPTH`, 8: per-lane input buffer entries; power of two, ≥2.
- `DW`, 8: width of the difficulty input.

Ports:
- `clk`  in  1  the only clock. Reset is synchronous and active-high.
- `rst`  in  1  synchronous active-high reset.
- `i_valid`  in  1  transaction offered.
- `i_transaction`  in  W  transaction word.
- `i_ready`  out  1  transaction consumed on this edge when `i_valid & i_ready`.
- `i_difficulty`  in  DW  required count of leading zero bits, sampled per transaction.
- `lane_valid_o`  out  LANES  lane k buffer non-empty (show-ahead).
- `lane_data_o`  out  LANES*W  head of lane k buffer, at bits [k*W +: W].
- `lane_ack_i`  in  LANES  pop lane k head. Ignored when `lane_valid_o[k]`=0.
- `res_valid_i`  in  LANES  lane k result available.
- `res_data_i`  in  LANES*W  lane k result, at bits [k*W +: W].
- `res_ack_o`  out  LANES  result k taken this cycle (combinational).
- `o_valid`  out  1  merged result valid.
- `o_hash`  out  W  merged result.
- `o_ready`  in  1  downstream accepts `o_hash` on this edge.
- `o_pass_count`  out  32  transactions dispatched to lanes.
- `o_drop_count`  out  32  transactions rejected by the filter.

## Operation
- **Filter.** Let d = `i_difficulty`. The transaction passes if `i_transaction[W-1 -: min(d,W)]` is all zero. d=0 always passes. d≥W passes only an all-zero word.
- **Dispatch.**
  - `dptr` (0..LANES-1) selects the target lane.
  - `i_ready` = !full[`dptr`]. This holds for dropped transactions too, so the filter never bypasses backpressure.
  - On a consumed passing transaction: write it into buffer[`dptr`], increment `dptr` modulo LANES, increment `o_pass_count`.
  - On a consumed failing transaction: no write, `dptr` unchanged, increment `o_drop_count`.
- **Lane buffers.** One `sync_fifo` per lane, show-ahead.
  - A lane pop requires `lane_ack_i[k] & lane_valid_o[k]`.
  - Write and pop in the same cycle are allowed at any fill level except a write when full, which `i_ready` already prevents.
- **Collect.**
  - `cptr` (0..LANES-1) names the lane whose result is next in order.
  - `res_ack_o[cptr]` = `res_valid_i[cptr]` & (!`o_valid` | `o_ready`). All other bits of `res_ack_o` are 0.
  - On ack: register the result into `o_hash`, set `o_valid`, increment `cptr` modulo LANES.
  - Results waiting on any other lane are held off until `cptr` reaches that lane.
- **Output register.** It holds its value while `o_valid & !o_ready`. It clears `o_valid` on `o_ready` when no new result is acked in the same cycle.
- **Counters.** Both saturate at 32'hFFFF_FFFF.
- **Ordering rule.** Each lane must return results in the order it popped them. Under that rule, output order equals input order of passing transactions.

## Timing
- **Reset values.**
  - All outputs 0: `i_ready`, `lane_valid_o`, `res_ack_o`, `o_valid`, `o_hash`, both counters.
  - `dptr` = `cptr` = 0 and all buffers empty. `i_ready` rises the cycle after `rst` deasserts.
- **Reset mid-operation.** Buffered transactions and the output register are discarded. Lanes must also be reset by the same `rst`.
- **Accept to lane.** A transaction accepted at edge t shows `lane_valid_o[k]`=1 with its data from edge t onward (1 cycle).
- **Result to output.** A result acked in cycle t shows `o_valid`=1 from edge t. Back-to-back results sustain 1 per cycle with `o_ready` held high.
- **Buffer full.** `i_ready`=0 while buffer[`dptr`] is full. The source stalls even if other lanes have room: strict rotation is required for ordering.
- **Simultaneous events.**
  - Pop of a full buffer in cycle t raises `i_ready` at t+1. There is no combinational ack→ready path.
  - `o_ready` and a new ack in the same cycle: the old result leaves and the new one loads; `o_valid` stays 1.
- **Wrap-around.** `dptr` and `cptr` go LANES-1 → 0. FIFO pointers carry an extra wrap bit for full/empty detection.

## Structure
- **Package `validator_pkg`:** default `W`/`LANES`/`DEPTH`/`DW` localparams, the counter width constant (32), and the saturating-increment function.
- **Sub-module `sync_fifo`:** show-ahead, parameters `W`/`DEPTH`, ports `clk`, `rst`, `wr_en`, `wr_data`, `rd_en`, `rd_data`, `empty`, `full`. Instantiated LANES times in a generate loop.
- **Top-level logic:** the filter compare, the dispatch and collect pointers, the output register and the counters.

## Test plan
- **Order across lanes.** LANES=4, d=0, 8 transactions 0x1..0x8; lanes ack immediately and return results in reverse lane timing → `o_hash` sequence 0x1..0x8. `o_pass_count`=8, each lane receives 2.
- **Filter.** d=4. Send 128'h0F…, 128'hF0…, 128'h0…; then d=200 with all-zero → pass, drop, pass, pass. `o_drop_count`=1, `dptr`=3.
- **Backpressure.** DEPTH=2, lanes never ack, 9 offered → 8 accepted, then `i_ready`=0 on lane 0 full. Ack lane 0 once → `i_ready`=1 the next cycle, 9th lands in lane 0.
- **Output stall.** Hold `o_ready`=0 for 5 cycles with results pending → `o_hash` stable, `res_ack_o`=0. Release → one result per cycle, no loss or duplication.
- **Reset mid-run.** Assert `rst` with 3 buffered transactions and `o_valid`=1 → next cycle all outputs 0. The post-reset transaction goes to lane 0.
- **Counter saturation.** Force `o_drop_count` to 32'hFFFF_FFFE, send 3 drops → count 32'hFFFF_FFFF.
